// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential mul/div issue controller.
// Holds the FSM state encoding, LAT counter width and the M-extension decode constants.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } md_state_e;

    // Wide enough for the largest legal settle count (15).
    localparam int unsigned LAT_CNT_W = 4;

    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_seq_ctrl.sv
// Issue/stall controller that feeds a combinational multicycle mul/div datapath.
// Operands are frozen at issue; divide-by-zero and signed overflow bypass the datapath.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [6:0]      opcode_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] md_in1_o,
    output logic [XLEN-1:0] md_in2_o,
    output logic [2:0]      md_funct3_o,
    input  logic [XLEN-1:0] md_result_i,
    output logic            stall_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o,
    output logic            busy_o
);

    localparam logic [LAT_CNT_W-1:0] MUL_LOAD = LAT_CNT_W'(MUL_CYCLES - 1);
    localparam logic [LAT_CNT_W-1:0] DIV_LOAD = LAT_CNT_W'(DIV_CYCLES - 1);
    localparam logic [XLEN-1:0]      INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e            state_q;
    logic [LAT_CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]      op1_q;
    logic [XLEN-1:0]      op2_q;
    logic [2:0]           f3_q;
    logic [XLEN-1:0]      result_q;

    logic            md_op;
    logic            div_zero;
    logic            div_ovf;
    logic            fast_path;
    logic [XLEN-1:0] special_val;

    assign md_op = valid_i && (opcode_i == OPCODE_R) && (funct7_i == FUNCT7_MULDIV);

    // funct3[2] selects divide, funct3[1] selects remainder, funct3[0] selects unsigned.
    always_comb begin
        div_zero    = 1'b0;
        div_ovf     = 1'b0;
        special_val = '0;
        if (funct3_i[2]) begin
            div_zero = (rs2_i == '0);
            div_ovf  = !funct3_i[0] && (rs1_i == INT_MIN) && (rs2_i == '1);
        end
        if (div_zero) begin
            special_val = funct3_i[1] ? rs1_i : '1;
        end else if (div_ovf) begin
            special_val = funct3_i[1] ? '0 : rs1_i;
        end
    end

    assign fast_path = div_zero || div_ovf;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            f3_q     <= '0;
            result_q <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (md_op) begin
                        op1_q <= rs1_i;
                        op2_q <= rs2_i;
                        f3_q  <= funct3_i;
                        if (fast_path) begin
                            result_q <= special_val;
                            state_q  <= ST_DONE;
                        end else begin
                            cnt_q   <= funct3_i[2] ? DIV_LOAD : MUL_LOAD;
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        result_q <= md_result_i;
                        state_q  <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall must rise in the issue cycle itself, so it cannot wait for the state register.
    assign stall_o = rst_ni && !flush_i &&
                     (((state_q == ST_IDLE) && md_op) || (state_q == ST_BUSY));

    assign result_valid_o = (state_q == ST_DONE) && !flush_i;
    assign busy_o         = (state_q == ST_BUSY) || (state_q == ST_DONE);
    assign result_o       = result_q;

    assign md_in1_o    = op1_q;
    assign md_in2_o    = op2_q;
    assign md_funct3_o = f3_q;

endmodule
